dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the byte-addressed data memory port.
- Requester 0 is the CPU load/store path; requester 1 is the DMA/loader.
- Grants one access per cycle, range- and alignment-checks each access, suppresses illegal writes, and returns registered read data.
- Supports locked bursts with a bounded length, so one requester cannot starve the other.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_addr_check.sv | 30 +++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose: requester count, arbiter state encoding and the request record
//          that the arbiter muxes from the winning requester.
// Ports:   none (package).

package dmem_arb_pkg;

   localparam int NUM_REQ = 2;
   localparam int DMEM_DW = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_LOCK0,
      ARB_LOCK1
   } arb_state_t;

   typedef struct packed {
      logic               we;
      logic               byte_op;
      logic [DMEM_DW-1:0] addr;
      logic [DMEM_DW-1:0] wd;
   } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-port bundle of the data-memory arbiter
//
// Purpose: groups both requester channels, the shared response channel and the
//          memory port so the arbiter and its environment connect through one handle.
// Ports (signals):
//   req_i/lock_i/we_i/byte_op_i [1:0]   per-requester request fields
//   addr_i/wd_i [1:0][DW-1:0]           per-requester address / write data
//   gnt_o/rvalid_o/err_o [1:0]          grant and registered response
//   rd_o [DW-1:0]                       shared registered read data
//   mem_we_o/mem_byte_op_o/mem_addr_o/mem_wd_o  memory request, mem_rd_i read data
// Modports: slave = arbiter side, master = requesters + memory side.

interface dmem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic [1:0]                 req_i;
   logic [1:0]                 lock_i;
   logic [1:0]                 we_i;
   logic [1:0]                 byte_op_i;
   logic [1:0][DATA_WIDTH-1:0] addr_i;
   logic [1:0][DATA_WIDTH-1:0] wd_i;
   logic [1:0]                 gnt_o;
   logic [1:0]                 rvalid_o;
   logic [1:0]                 err_o;
   logic [DATA_WIDTH-1:0]      rd_o;
   logic                       mem_we_o;
   logic                       mem_byte_op_o;
   logic [DATA_WIDTH-1:0]      mem_addr_o;
   logic [DATA_WIDTH-1:0]      mem_wd_o;
   logic [DATA_WIDTH-1:0]      mem_rd_i;

   modport slave (
      input  req_i, lock_i, we_i, byte_op_i, addr_i, wd_i, mem_rd_i,
      output gnt_o, rvalid_o, err_o, rd_o,
      output mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
   );

   modport master (
      output req_i, lock_i, we_i, byte_op_i, addr_i, wd_i, mem_rd_i,
      input  gnt_o, rvalid_o, err_o, rd_o,
      input  mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
   );
endinterface

// File: rtl/dmem_addr_check.sv
// rtl/dmem_addr_check.sv - range and alignment check of one memory access
//
// Purpose: flags an access that falls outside [START_ADDRESS, END_ADDRESS]
//          or is a misaligned word access. Purely combinational.
// Ports:
//   addr     in  DATA_WIDTH  byte address of the access
//   byte_op  in  1           1 = byte access, 0 = word access
//   illegal  out 1           access must not reach memory

module dmem_addr_check #(
   parameter int                    DATA_WIDTH    = 32,
   parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 'h10000,
   parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 'h1FFFF
) (
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic                  byte_op,
   output logic                  illegal
);

   // Last byte touched, one bit wider so an access near the top of the
   // address space cannot wrap around and look legal.
   logic [DATA_WIDTH:0] last_byte;

   assign last_byte = {1'b0, addr} + (byte_op ? (DATA_WIDTH+1)'(0) : (DATA_WIDTH+1)'(3));

   assign illegal = (addr < START_ADDRESS)
                 || (last_byte > {1'b0, END_ADDRESS})
                 || (!byte_op && (addr[1:0] != 2'b00));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter/sequencer for the data memory port
//
// Purpose: grants one access per cycle (round-robin on ties, bounded locked
//          bursts), checks legality, suppresses illegal writes and returns a
//          registered response one cycle after each transfer.
// Ports:
//   clk_i   in  1   clock
//   rst_ni  in  1   asynchronous active-low reset
//   bus     slave   requester channels, response channel and memory port

module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int                    DATA_WIDTH    = DMEM_DW,
   parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 'h10000,
   parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 'h1FFFF,
   parameter int                    MAX_BURST     = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   dmem_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t            state_q, state_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
   logic                  last_winner_q, last_winner_d;

   logic [NUM_REQ-1:0]    gnt;
   logic                  transfer;
   logic                  winner;
   logic                  owner;
   dmem_req_t             sel_req;
   logic                  illegal;

   logic [NUM_REQ-1:0]    rvalid_q, err_q;
   logic [DATA_WIDTH-1:0] rd_q;

   // Grant depends only on requests and registered state, never on mem_rd_i.
   always_comb begin
      gnt = '0;
      case (state_q)
         ARB_IDLE: begin
            if (bus.req_i == 2'b11) gnt = last_winner_q ? 2'b01 : 2'b10;
            else                    gnt = bus.req_i;
         end
         ARB_LOCK0: gnt = {1'b0, bus.req_i[0]};
         ARB_LOCK1: gnt = {bus.req_i[1], 1'b0};
         default:   gnt = '0;
      endcase
   end

   assign transfer = |gnt;
   assign winner   = gnt[1];
   assign owner    = (state_q == ARB_LOCK1);

   // Without a grant the muxed request is all zero, which also zeroes mem_*.
   always_comb begin
      sel_req = '0;
      if (transfer) begin
         sel_req.we      = bus.we_i[winner];
         sel_req.byte_op = bus.byte_op_i[winner];
         sel_req.addr    = bus.addr_i[winner];
         sel_req.wd      = bus.wd_i[winner];
      end
   end

   dmem_addr_check #(
      .DATA_WIDTH    (DATA_WIDTH),
      .START_ADDRESS (START_ADDRESS),
      .END_ADDRESS   (END_ADDRESS)
   ) u_addr_check (
      .addr    (sel_req.addr),
      .byte_op (sel_req.byte_op),
      .illegal (illegal)
   );

   assign bus.mem_we_o      = sel_req.we & ~illegal;
   assign bus.mem_byte_op_o = sel_req.byte_op;
   assign bus.mem_addr_o    = sel_req.addr;
   assign bus.mem_wd_o      = sel_req.wd;

   always_comb begin
      state_d       = state_q;
      burst_cnt_d   = burst_cnt_q;
      last_winner_d = transfer ? winner : last_winner_q;
      case (state_q)
         ARB_IDLE: begin
            // A single-grant cap means the first transfer already exhausts the burst.
            if (transfer && bus.lock_i[winner] && (MAX_BURST > 1)) begin
               state_d     = winner ? ARB_LOCK1 : ARB_LOCK0;
               burst_cnt_d = CNT_W'(1);
            end
         end
         ARB_LOCK0, ARB_LOCK1: begin
            if (!bus.lock_i[owner]) begin
               state_d     = ARB_IDLE;
               burst_cnt_d = '0;
            end else if (transfer) begin
               if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  state_d     = ARB_IDLE;
                  burst_cnt_d = '0;
               end else begin
                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d     = ARB_IDLE;
            burst_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ARB_IDLE;
         burst_cnt_q   <= '0;
         last_winner_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         burst_cnt_q   <= burst_cnt_d;
         last_winner_q <= last_winner_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= '0;
         err_q    <= '0;
         rd_q     <= '0;
      end else begin
         rvalid_q <= gnt;
         err_q    <= illegal ? gnt : '0;
         rd_q     <= (transfer && !sel_req.we && !illegal) ? bus.mem_rd_i : '0;
      end
   end

   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = rvalid_q;
   assign bus.err_o    = err_q;
   assign bus.rd_o     = rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

   localparam int MAX_BURST = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   dmem_arbiter #(
      .DATA_WIDTH    (32),
      .START_ADDRESS (32'h10000),
      .END_ADDRESS   (32'h1FFFF),
      .MAX_BURST     (MAX_BURST)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   logic [31:0] mem     [0:16383];
   logic [31:0] ref_mem [0:16383];

   assign bus.mem_rd_i = mem[bus.mem_addr_o[15:2]];

   always @(negedge clk) begin
      if (bus.mem_we_o) begin
         if (bus.mem_byte_op_o)
            mem[bus.mem_addr_o[15:2]][bus.mem_addr_o[1:0]*8 +: 8] <= bus.mem_wd_o[7:0];
         else
            mem[bus.mem_addr_o[15:2]] <= bus.mem_wd_o;
      end
   end

   int compared   = 0;
   int mismatched = 0;

   // Reference arbitration state: lock owner (-1 = nobody), grants in the
   // current burst, and the most recent winner.
   int own;
   int burst;
   int last;

   logic [1:0]  got_gnt, got_rv, got_err;
   logic        got_mem_we;
   logic [31:0] got_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_illegal(input logic [31:0] a, input logic b);
      longint la;
      longint lb;
      la = longint'(a);
      lb = la + (b ? 0 : 3);
      return (la < 'h10000) || (lb > 'h1FFFF) || (!b && (la % 4) != 0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - 32'h10000) >> 2);
   endfunction

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic cycle();
      int          g;
      bit          ill;
      logic [1:0]  eg;
      logic [1:0]  e_err;
      logic [31:0] e_rd;
      logic [31:0] a;
      logic        e_we;
      #2;
      g = -1;
      if (own >= 0) begin
         if (bus.req_i[own]) g = own;
      end else if (bus.req_i == 2'b11) g = 1 - last;
      else if (bus.req_i[0]) g = 0;
      else if (bus.req_i[1]) g = 1;
      eg    = (g < 0) ? 2'b00 : (2'b01 << g);
      ill   = 1'b0;
      e_we  = 1'b0;
      e_rd  = '0;
      e_err = 2'b00;
      got_gnt    = bus.gnt_o;
      got_mem_we = bus.mem_we_o;
      chk("gnt", {30'd0, got_gnt}, {30'd0, eg});
      if (g >= 0) begin
         a    = bus.addr_i[g];
         ill  = ref_illegal(a, bus.byte_op_i[g]);
         e_we = bus.we_i[g] && !ill;
         if (ill) e_err = eg;
         if (!ill && !bus.we_i[g]) e_rd = ref_mem[widx(a)];
         chk("mem_addr", bus.mem_addr_o, a);
         chk("mem_wd", bus.mem_wd_o, bus.wd_i[g]);
         chk("mem_byte_op", {31'd0, bus.mem_byte_op_o}, {31'd0, bus.byte_op_i[g]});
         if (e_we) begin
            if (bus.byte_op_i[g]) ref_mem[widx(a)][a[1:0]*8 +: 8] = bus.wd_i[g][7:0];
            else                  ref_mem[widx(a)] = bus.wd_i[g];
         end
      end else begin
         chk("mem_idle", {bus.mem_addr_o | bus.mem_wd_o}, 32'd0);
      end
      chk("mem_we", {31'd0, got_mem_we}, {31'd0, e_we});

      if (g >= 0) last = g;
      if (own >= 0) begin
         if (!bus.lock_i[own]) begin
            own = -1; burst = 0;
         end else if (g >= 0) begin
            burst++;
            if (burst == MAX_BURST) begin own = -1; burst = 0; end
         end
      end else if (g >= 0 && bus.lock_i[g] && MAX_BURST > 1) begin
         own = g; burst = 1;
      end

      @(posedge clk);
      #1;
      got_rv  = bus.rvalid_o;
      got_err = bus.err_o;
      got_rd  = bus.rd_o;
      chk("rvalid", {30'd0, got_rv}, {30'd0, eg});
      chk("err", {30'd0, got_err}, {30'd0, e_err});
      chk("rd", got_rd, e_rd);
   endtask

   task automatic set_req(input int n, input logic we, input logic b,
                          input logic [31:0] a, input logic [31:0] wd);
      bus.req_i[n]     = 1'b1;
      bus.we_i[n]      = we;
      bus.byte_op_i[n] = b;
      bus.addr_i[n]    = a;
      bus.wd_i[n]      = wd;
   endtask

   function automatic logic [31:0] gen_addr();
      case ($urandom_range(0, 15))
         0:       return 32'h0000_FFFC;
         1:       return 32'h0001_FFFC + $urandom_range(0, 3);
         2:       return 32'h0002_0000;
         3:       return 32'h0001_0000 + $urandom_range(0, 255);
         default: return 32'h0001_0000 + ($urandom_range(0, 31) << 2);
      endcase
   endfunction

   task automatic model_reset();
      own = -1; burst = 0; last = 1;
   endtask

   logic [1:0] tie_seq [4];

   initial begin
      for (int i = 0; i < 16384; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
      mem[2] = 32'hA5A5_0001; ref_mem[2] = 32'hA5A5_0001;
      tie_seq[0] = 2'b01; tie_seq[1] = 2'b10; tie_seq[2] = 2'b01; tie_seq[3] = 2'b10;

      rst_n         = 1'b0;
      bus.req_i     = '0;
      bus.lock_i    = '0;
      bus.we_i      = '0;
      bus.byte_op_i = '0;
      bus.addr_i    = '0;
      bus.wd_i      = '0;
      model_reset();
      #3;
      chk("rst_gnt", {30'd0, bus.gnt_o}, 32'd0);
      chk("rst_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
      chk("rst_err", {30'd0, bus.err_o}, 32'd0);
      chk("rst_rd", bus.rd_o, 32'd0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Tie round-robin from reset: requester 0 first.
      set_req(0, 1'b0, 1'b0, 32'h1_0008, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'h1_000C, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("tie_gnt", {30'd0, got_gnt}, {30'd0, tie_seq[i]});
         chk("tie_rvalid", {30'd0, got_rv}, {30'd0, tie_seq[i]});
      end
      bus.req_i = 2'b00;

      // Single word read.
      set_req(0, 1'b0, 1'b0, 32'h1_0004, 32'd0);
      cycle();
      chk("single_gnt", {30'd0, got_gnt}, 32'd1);
      chk("single_rd", got_rd, 32'hDEAD_BEEF);
      chk("single_err", {30'd0, got_err}, 32'd0);
      bus.req_i = 2'b00;

      // Locked burst capped at MAX_BURST, then forced release to requester 0.
      set_req(0, 1'b0, 1'b0, 32'h1_0010, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'h1_0014, 32'd0);
      bus.lock_i = 2'b10;
      for (int i = 0; i < MAX_BURST + 1; i++) begin
         cycle();
         chk("burst_gnt", {30'd0, got_gnt}, (i < MAX_BURST) ? 32'd2 : 32'd1);
      end
      bus.req_i  = 2'b00;
      bus.lock_i = 2'b00;
      cycle();

      // Illegal and boundary accesses.
      set_req(0, 1'b1, 1'b0, 32'h1_FFFE, 32'h1234_5678);
      cycle();
      chk("ill_wr_we", {31'd0, got_mem_we}, 32'd0);
      chk("ill_wr_err", {30'd0, got_err}, 32'd1);
      chk("ill_wr_rd", got_rd, 32'd0);
      set_req(0, 1'b1, 1'b1, 32'h1_FFFF, 32'h0000_00C3);
      cycle();
      chk("top_byte_we", {31'd0, got_mem_we}, 32'd1);
      chk("top_byte_err", {30'd0, got_err}, 32'd0);
      set_req(0, 1'b0, 1'b0, 32'h1_0002, 32'd0);
      cycle();
      chk("misalign_err", {30'd0, got_err}, 32'd1);
      bus.req_i = 2'b00;

      // Lock held by an idle owner blocks the other requester.
      set_req(0, 1'b0, 1'b0, 32'h1_0020, 32'd0);
      bus.lock_i = 2'b01;
      cycle();
      chk("lock0_gnt", {30'd0, got_gnt}, 32'd1);
      bus.req_i = 2'b00;
      set_req(1, 1'b0, 1'b0, 32'h1_0024, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("idle_owner_gnt", {30'd0, got_gnt}, 32'd0);
      end
      bus.lock_i = 2'b00;
      cycle();
      chk("unlock_cycle_gnt", {30'd0, got_gnt}, 32'd0);
      cycle();
      chk("after_unlock_gnt", {30'd0, got_gnt}, 32'd2);
      bus.req_i = 2'b00;

      // Reset while requester 1 owns a burst and a read response is pending.
      set_req(1, 1'b0, 1'b0, 32'h1_0008, 32'd0);
      bus.lock_i = 2'b10;
      cycle();
      chk("pre_rst_rvalid", {30'd0, got_rv}, 32'd2);
      rst_n      = 1'b0;
      bus.req_i  = 2'b00;
      bus.lock_i = 2'b00;
      #1;
      chk("mid_rst_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
      chk("mid_rst_err", {30'd0, bus.err_o}, 32'd0);
      chk("mid_rst_rd", bus.rd_o, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 32'h1_0004, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'h1_0008, 32'd0);
      cycle();
      chk("post_rst_tie", {30'd0, got_gnt}, 32'd1);
      bus.req_i = 2'b00;
      got_gnt   = 2'b00;

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!bus.req_i[n] || got_gnt[n]) begin
               if ($urandom_range(0, 3) != 0)
                  set_req(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                          gen_addr(), $urandom);
               else
                  bus.req_i[n] = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) bus.lock_i[n] = ~bus.lock_i[n];
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
